// File: rtl/bram_responder_if.sv
// Kernel-facing ce/we memory ports plus host load/dump stream and status for one BRAM.
interface bram_responder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  ce0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] address0;
    logic [DATA_WIDTH-1:0] dout0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  ce1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] address1;
    logic [DATA_WIDTH-1:0] dout1;
    logic [DATA_WIDTH-1:0] din1;
    logic                  load_start;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_valid;
    logic                  load_ready;
    logic                  dump_start;
    logic [DATA_WIDTH-1:0] dump_data;
    logic                  dump_valid;
    logic                  dump_ready;
    logic                  done;
    logic [CNT_WIDTH-1:0]  rd_count;
    logic [CNT_WIDTH-1:0]  wr_count;
    logic                  err;

    // Memory side
    modport slave (
        input  ce0, we0, address0, dout0,
        output din0,
        input  ce1, we1, address1, dout1,
        output din1,
        input  load_start, load_data, load_valid,
        output load_ready,
        input  dump_start, dump_ready,
        output dump_data, dump_valid,
        output done, rd_count, wr_count, err
    );

    // Kernel / host side
    modport master (
        output ce0, we0, address0, dout0,
        input  din0,
        output ce1, we1, address1, dout1,
        input  din1,
        output load_start, load_data, load_valid,
        input  load_ready,
        output dump_start, dump_ready,
        input  dump_data, dump_valid,
        input  done, rd_count, wr_count, err
    );
endinterface

// File: rtl/bram_responder.sv
// Dual-port BRAM responder: serves kernel ce/we accesses, with host preload and dump streams.
module bram_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    bram_responder_if.slave bus
);
    localparam int unsigned    CNT_EXT = CNT_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {SERVE, LOAD, DUMP} state_t;

    state_t                state_q, state_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_q, idx_nxt;
    logic [DATA_WIDTH-1:0] din0_q, din0_nxt, din1_q, din1_nxt;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_nxt;
    logic                  load_ready_q, load_ready_nxt;
    logic                  dump_valid_q, dump_valid_nxt;
    logic                  done_q, done_nxt;
    logic                  err_q, err_nxt;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_nxt, wr_count_q, wr_count_nxt;

    logic in_range0, in_range1;
    logic rd0, rd1, wr0, wr1;
    logic collide, err_evt;
    logic load_fire, dump_fire;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + CNT_EXT'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Qualify kernel accesses and detect error conditions
    always_comb begin
        in_range0 = {1'b0, bus.address0} < DEPTH_W;
        in_range1 = {1'b0, bus.address1} < DEPTH_W;
        rd0       = (state_q == SERVE) && bus.ce0 && !bus.we0 && in_range0;
        rd1       = (state_q == SERVE) && bus.ce1 && !bus.we1 && in_range1;
        wr0       = (state_q == SERVE) && bus.ce0 && bus.we0 && in_range0;
        wr1       = (state_q == SERVE) && bus.ce1 && bus.we1 && in_range1;
        collide   = wr0 && wr1 && (bus.address0 == bus.address1);
        load_fire = (state_q == LOAD) && bus.load_valid && load_ready_q;
        dump_fire = (state_q == DUMP) && dump_valid_q && bus.dump_ready;
        if (state_q == SERVE) begin
            err_evt = (bus.ce0 && !in_range0) || (bus.ce1 && !in_range1) || collide
                      || (bus.load_start && bus.dump_start);
        end else begin
            err_evt = bus.ce0 || bus.ce1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SERVE;
        else     state_q <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SERVE: begin
                if (bus.load_start)      state_nxt = LOAD;
                else if (bus.dump_start) state_nxt = DUMP;
            end
            LOAD:    if (load_fire && idx_q == LAST) state_nxt = SERVE;
            DUMP:    if (dump_fire && idx_q == LAST) state_nxt = SERVE;
            default: state_nxt = SERVE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        idx_nxt        = idx_q;
        din0_nxt       = din0_q;
        din1_nxt       = din1_q;
        load_ready_nxt = load_ready_q;
        dump_valid_nxt = dump_valid_q;
        dump_data_nxt  = dump_data_q;
        done_nxt       = 1'b0;
        rd_count_nxt   = sat_add(rd_count_q, {1'b0, rd0} + {1'b0, rd1});
        wr_count_nxt   = sat_add(wr_count_q, {1'b0, wr0} + {1'b0, wr1});
        err_nxt        = err_q | err_evt;
        case (state_q)
            SERVE: begin
                if (rd0) din0_nxt = mem[bus.address0];
                if (rd1) din1_nxt = mem[bus.address1];
                if (bus.load_start) begin
                    // A fresh preload starts a clean run; a colliding dump_start is still flagged
                    idx_nxt        = '0;
                    load_ready_nxt = 1'b1;
                    rd_count_nxt   = '0;
                    wr_count_nxt   = '0;
                    err_nxt        = bus.dump_start;
                end else if (bus.dump_start) begin
                    idx_nxt        = '0;
                    dump_valid_nxt = 1'b0;
                end
            end
            LOAD: begin
                if (load_fire) begin
                    idx_nxt = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == LAST) begin
                        load_ready_nxt = 1'b0;
                        done_nxt       = 1'b1;
                    end
                end
            end
            DUMP: begin
                // Alternate between issuing a read and holding the word until accepted
                if (!dump_valid_q) begin
                    dump_valid_nxt = 1'b1;
                    dump_data_nxt  = mem[idx_q];
                end else if (bus.dump_ready) begin
                    dump_valid_nxt = 1'b0;
                    idx_nxt        = idx_q + ADDR_WIDTH'(1);
                    if (idx_q == LAST) done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            din0_q       <= '0;
            din1_q       <= '0;
            dump_data_q  <= '0;
            load_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
        end else begin
            idx_q        <= idx_nxt;
            din0_q       <= din0_nxt;
            din1_q       <= din1_nxt;
            dump_data_q  <= dump_data_nxt;
            load_ready_q <= load_ready_nxt;
            dump_valid_q <= dump_valid_nxt;
            done_q       <= done_nxt;
            err_q        <= err_nxt;
            rd_count_q   <= rd_count_nxt;
            wr_count_q   <= wr_count_nxt;
        end
    end

    // Memory array writes; port 1 is last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (load_fire) mem[idx_q] <= bus.load_data;
        if (wr0)       mem[bus.address0] <= bus.dout0;
        if (wr1)       mem[bus.address1] <= bus.dout1;
    end

    assign bus.din0       = din0_q;
    assign bus.din1       = din1_q;
    assign bus.dump_data  = dump_data_q;
    assign bus.load_ready = load_ready_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.rd_count   = rd_count_q;
    assign bus.wr_count   = wr_count_q;
endmodule

// File: tb/tb_bram_responder.sv
// Randomized bench for bram_responder with a transaction-level memory model.
module tb_bram_responder;
    localparam int MD = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bram_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CNT_WIDTH(16)) bus ();
    bram_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CNT_WIDTH(2))  sbus ();

    bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(128), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    bram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .DEPTH(100), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endfunction

    // Behavioural model: memory contents, mode and expected outputs
    logic [7:0] m [MD];
    int         mdl_mode = 0;    // 0 kernel, 1 preload, 2 dump
    int         ld_idx = 0;
    int         dp_idx = 0;
    int         nrd, nwr;
    logic [7:0] e_din0 = 0, e_din1 = 0, e_dump_data = 0;
    logic       e_load_ready = 0, e_dump_valid = 0, e_done = 0, e_err = 0;
    int         e_rd = 0, e_wr = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mdl_mode = 0; e_din0 = 0; e_din1 = 0; e_dump_data = 0;
                e_load_ready = 0; e_dump_valid = 0; e_done = 0; e_err = 0;
                e_rd = 0; e_wr = 0;
            end else begin
                e_done = 0;
                if (mdl_mode == 0) begin
                    nrd = 0; nwr = 0;
                    if (bus.ce0 && int'(bus.address0) >= MD) e_err = 1;
                    if (bus.ce1 && int'(bus.address1) >= MD) e_err = 1;
                    if (bus.ce0 && !bus.we0 && int'(bus.address0) < MD) begin
                        e_din0 = m[bus.address0]; nrd++;
                    end
                    if (bus.ce1 && !bus.we1 && int'(bus.address1) < MD) begin
                        e_din1 = m[bus.address1]; nrd++;
                    end
                    if (bus.ce0 && bus.we0 && int'(bus.address0) < MD) begin
                        m[bus.address0] = bus.dout0; nwr++;
                    end
                    if (bus.ce1 && bus.we1 && int'(bus.address1) < MD) begin
                        if (bus.ce0 && bus.we0 && bus.address0 == bus.address1) e_err = 1;
                        m[bus.address1] = bus.dout1; nwr++;
                    end
                    e_rd = (e_rd + nrd > 65535) ? 65535 : e_rd + nrd;
                    e_wr = (e_wr + nwr > 65535) ? 65535 : e_wr + nwr;
                    if (bus.load_start) begin
                        mdl_mode = 1; ld_idx = 0; e_load_ready = 1;
                        e_rd = 0; e_wr = 0; e_err = bus.dump_start;
                    end else if (bus.dump_start) begin
                        mdl_mode = 2; dp_idx = 0;
                    end
                end else begin
                    if (bus.ce0 || bus.ce1) e_err = 1;
                    if (mdl_mode == 1) begin
                        if (bus.load_valid && e_load_ready) begin
                            m[ld_idx] = bus.load_data;
                            ld_idx++;
                            if (ld_idx == MD) begin
                                mdl_mode = 0; e_load_ready = 0; e_done = 1;
                            end
                        end
                    end else begin
                        if (!e_dump_valid) begin
                            e_dump_valid = 1; e_dump_data = m[dp_idx];
                        end else if (bus.dump_ready) begin
                            e_dump_valid = 0;
                            dp_idx++;
                            if (dp_idx == MD) begin
                                e_done = 1; mdl_mode = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the active edge
    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("din0", 32'(bus.din0), 32'(e_din0));
            chk("din1", 32'(bus.din1), 32'(e_din1));
            chk("load_ready", 32'(bus.load_ready), 32'(e_load_ready));
            chk("dump_valid", 32'(bus.dump_valid), 32'(e_dump_valid));
            if (e_dump_valid) chk("dump_data", 32'(bus.dump_data), 32'(e_dump_data));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("err", 32'(bus.err), 32'(e_err));
            chk("rd_count", 32'(bus.rd_count), 32'(e_rd));
            chk("wr_count", 32'(bus.wr_count), 32'(e_wr));
        end
    end

    // Record every accepted dump word
    logic [7:0] dumped [$];
    initial begin
        forever begin
            @(posedge clk);
            if (bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) dumped.push_back(bus.dump_data);
        end
    end

    logic [7:0] pat [MD];
    int ready_cycles, done_cnt;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input int n_words);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        ready_cycles = 0;
        done_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (bus.load_ready === 1'b1) ready_cycles++;
            if (bus.done === 1'b1) done_cnt++;
            if (ld_idx >= n_words) break;
            bus.load_data = pat[ld_idx];
            tick();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic dump_run(input int inject_at);
        dumped.delete();
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.done === 1'b1) done_cnt++;
            if (mdl_mode == 0) break;
            bus.ce0 = (c == inject_at);
            bus.we0 = 1'b0;
            bus.address0 = 7'd0;
            tick();
            bus.dump_ready = ~bus.dump_ready;
        end
        bus.ce0 = 1'b0;
        bus.dump_ready = 1'b0;
        chk("dump_done_pulses", 32'(done_cnt), 32'd1);
        chk("dump_word_count", 32'(dumped.size()), 32'd128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.ce0, bus.we0, bus.ce1, bus.we1} = '0;
        bus.address0 = '0; bus.address1 = '0; bus.dout0 = '0; bus.dout1 = '0;
        bus.load_start = 0; bus.load_data = '0; bus.load_valid = 0;
        bus.dump_start = 0; bus.dump_ready = 0;
        {sbus.ce0, sbus.we0, sbus.ce1, sbus.we1} = '0;
        sbus.address0 = '0; sbus.address1 = '0; sbus.dout0 = '0; sbus.dout1 = '0;
        sbus.load_start = 0; sbus.load_data = '0; sbus.load_valid = 0;
        sbus.dump_start = 0; sbus.dump_ready = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_rd_count", 32'(bus.rd_count), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_din0", 32'(bus.din0), 32'd0);
        chk("reset_load_ready", 32'(bus.load_ready), 32'd0);

        // Preload identity pattern
        for (int i = 0; i < MD; i++) pat[i] = 8'(i);
        preload(MD);
        chk("preload_ready_cycles", 32'(ready_cycles), 32'd128);
        chk("preload_done_pulses", 32'(done_cnt), 32'd1);

        // Single read with hold
        bus.ce0 = 1; bus.we0 = 0; bus.address0 = 7'd5;
        tick();
        chk("read5_din0", 32'(bus.din0), 32'h05);
        bus.ce0 = 0;
        tick();
        chk("read5_hold", 32'(bus.din0), 32'h05);
        chk("read5_rd_count", 32'(bus.rd_count), 32'd1);

        // Read-first on a same-cycle write from the other port
        bus.ce1 = 1; bus.we1 = 1; bus.address1 = 7'd9; bus.dout1 = 8'hAA;
        bus.ce0 = 1; bus.we0 = 0; bus.address0 = 7'd9;
        tick();
        chk("rdfirst_din0", 32'(bus.din0), 32'h09);
        chk("rdfirst_wr_count", 32'(bus.wr_count), 32'd1);
        chk("rdfirst_rd_count", 32'(bus.rd_count), 32'd2);
        bus.ce1 = 0;
        tick();
        chk("reread9_din0", 32'(bus.din0), 32'hAA);

        // Both ports write address 3
        bus.ce0 = 1; bus.we0 = 1; bus.address0 = 7'd3; bus.dout0 = 8'h11;
        bus.ce1 = 1; bus.we1 = 1; bus.address1 = 7'd3; bus.dout1 = 8'h22;
        tick();
        chk("collide_err", 32'(bus.err), 32'd1);
        bus.ce1 = 0; bus.we0 = 0;
        tick();
        chk("collide_port1_wins", 32'(bus.din0), 32'h22);
        chk("collide_wr_count", 32'(bus.wr_count), 32'd3);
        bus.ce0 = 0;
        tick();

        // Dump with dump_ready toggling
        dump_run(-1);
        if (dumped.size() == MD) begin
            for (int i = 0; i < MD; i++)
                chk("dump1_word", 32'(dumped[i]), (i == 3) ? 32'h22 : (i == 9) ? 32'hAA : 32'(i));
        end

        // Random preload then random kernel traffic
        for (int i = 0; i < MD; i++) pat[i] = 8'($urandom);
        preload(MD);
        chk("preload2_err_cleared", 32'(bus.err), 32'd0);
        chk("preload2_rd_cleared", 32'(bus.rd_count), 32'd0);
        for (int c = 0; c < 300; c++) begin
            bus.ce0 = 1'($urandom_range(0, 1)); bus.we0 = 1'($urandom_range(0, 1));
            bus.ce1 = 1'($urandom_range(0, 1)); bus.we1 = 1'($urandom_range(0, 1));
            if (c < 150) begin
                bus.address0 = 7'($urandom_range(0, 63));
                bus.address1 = 7'($urandom_range(64, 127));
            end else begin
                bus.address0 = 7'($urandom_range(0, 127));
                bus.address1 = ($urandom_range(0, 3) == 0) ? bus.address0 : 7'($urandom_range(0, 127));
            end
            bus.dout0 = 8'($urandom); bus.dout1 = 8'($urandom);
            tick();
            if (c == 149) chk("clean_traffic_err", 32'(bus.err), 32'd0);
        end
        {bus.ce0, bus.we0, bus.ce1, bus.we1} = '0;
        tick();

        // Partial preload interrupted by reset, then dump with a stray kernel access
        for (int i = 0; i < MD; i++) pat[i] = 8'($urandom);
        preload(40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
        chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        dump_run(7);
        chk("dump_ce_err", 32'(bus.err), 32'd1);
        if (dumped.size() == MD) begin
            for (int i = 0; i < 40; i++) chk("partial_word", 32'(dumped[i]), 32'(pat[i]));
        end

        // DEPTH=100, CNT_WIDTH=2 instance: range check and counter saturation
        sbus.ce0 = 1; sbus.we0 = 1; sbus.address0 = 7'd99; sbus.dout0 = 8'h5C;
        tick();
        chk("sb_wr_count", 32'(sbus.wr_count), 32'd1);
        sbus.we0 = 0; sbus.ce1 = 1; sbus.we1 = 0; sbus.address1 = 7'd99;
        tick();
        chk("sb_din0", 32'(sbus.din0), 32'h5C);
        chk("sb_din1", 32'(sbus.din1), 32'h5C);
        chk("sb_rd_count", 32'(sbus.rd_count), 32'd2);
        tick();
        chk("sb_rd_saturate", 32'(sbus.rd_count), 32'd3);
        chk("sb_err_clean", 32'(sbus.err), 32'd0);
        sbus.ce0 = 0; sbus.address1 = 7'd127;
        tick();
        chk("sb_oob_err", 32'(sbus.err), 32'd1);
        chk("sb_oob_rd_count", 32'(sbus.rd_count), 32'd3);
        chk("sb_oob_din1_held", 32'(sbus.din1), 32'h5C);
        sbus.ce1 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Dual-port BRAM model that acts as the memory end of the ce/we/address/dout/din interface driven by the kernel-side memory converters.
- Answers kernel reads with 1-cycle latency and commits kernel writes.
- Gives the bench/host a valid/ready stream side to preload contents before a run and dump contents after it.
- One instance per kernel array (e.g. matrix, vector, result), placed directly outside the wrapped kernel.

Parameters:
DATA_WIDTH, 8, word width
ADDR_WIDTH, 7, address width
DEPTH, 128, number of words; legal range 1..2**ADDR_WIDTH
CNT_WIDTH, 16, width of the access counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ce0  in  1  port 0 enable
we0  in  1  port 0 write enable
address0  in  ADDR_WIDTH  port 0 address
dout0  in  DATA_WIDTH  port 0 write data (kernel to memory)
din0  out  DATA_WIDTH  port 0 read data (memory to kernel)
ce1  in  1  port 1 enable
we1  in  1  port 1 write enable
address1  in  ADDR_WIDTH  port 1 address
dout1  in  DATA_WIDTH  port 1 write data
din1  out  DATA_WIDTH  port 1 read data
load_start  in  1  pulse: begin preload
load_data  in  DATA_WIDTH  preload word
load_valid  in  1  preload word valid
load_ready  out  1  preload word accepted
dump_start  in  1  pulse: begin dump
dump_data  out  DATA_WIDTH  dumped word
dump_valid  out  1  dumped word valid
dump_ready  in  1  host accepts dumped word
done  out  1  1-cycle pulse when a LOAD or DUMP completes
rd_count  out  CNT_WIDTH  kernel reads served
wr_count  out  CNT_WIDTH  kernel writes committed
err  out  1  sticky error flag

Behaviour:

Reset values:
- State SERVE.
- din0, din1, dump_data, rd_count, wr_count: 0.
- load_ready, dump_valid, done, err: 0.
- Memory contents are not reset.

States:
- SERVE (kernel owns the memory):
  - load_start moves to LOAD; dump_start moves to DUMP.
  - If both are asserted in the same cycle, load_start wins and err is set.
  - Start pulses in LOAD/DUMP are ignored.
- LOAD:
  - load_ready=1.
  - Each load_valid&load_ready cycle writes load_data to mem[idx] and increments idx (starts at 0).
  - After the write at idx=DEPTH-1: done pulses the next cycle, load_ready drops, state returns to SERVE.
  - Entering LOAD clears rd_count, wr_count and err.
- DUMP:
  - idx starts at 0. Issue a read of mem[idx]; dump_data/dump_valid are registered the next cycle.
  - dump_valid and dump_data are held stable until dump_ready; the transfer occurs on dump_valid&dump_ready.
  - After a transfer, the next read is issued, so sustained throughput is 1 word per 2 cycles.
  - After idx=DEPTH-1 transfers: done pulses, back to SERVE.
  - The memory is not modified.

Kernel port rules (SERVE only):
- Read (ce&!we): din<=mem[address] at the clock edge, visible the following cycle. din holds its value when ce=0.
- Write (ce&we): mem[address]<=dout at the edge; din of that port is unchanged.
- Read-first: a read and a write to the same address in the same cycle return the old data.
- Both ports writing the same address: port 1 wins, err set.
- Address >= DEPTH: access dropped, err set.
- rd_count/wr_count increment once per served read/write per port; both ports active in one cycle add 2.
- Counters saturate at all-ones.

Kernel access outside SERVE:
- Any ce0/ce1 during LOAD/DUMP is dropped, din held, err set.

Reset mid-operation:
- Asynchronous return to SERVE; any partial preload remains in memory; dump aborts with dump_valid=0.

Test Plan:
- Preload DEPTH=128 words 0x00..0x7F with load_valid held 1 -> load_ready high for 128 cycles, done pulses once, state SERVE.
- After preload: port0 read address 5 at cycle t -> din0=0x05 at t+1; ce0 low at t+1 -> din0 still 0x05 at t+2; rd_count=1.
- Same cycle: port1 writes 0xAA to address 9, port0 reads address 9 -> din0=0x09; next-cycle read of 9 -> 0xAA; wr_count=1, rd_count=2.
- Both ports write address 3 (0x11 on port0, 0x22 on port1) -> mem[3]=0x22, err=1; access to address 0x7F+ with DEPTH=100 -> dropped, err=1.
- Dump with dump_ready toggling 1,0,1,... -> 128 words in address order, each word stable while dump_ready=0, done pulses after the last word.
- Assert rst after 40 preload words, then dump -> words 0..39 match the preload; rd_count=wr_count=0 after rst; a ce0 asserted during the dump sets err.
